// File: rtl/alloc_scheduler_if.sv
// alloc_scheduler_if: groups the requester handshakes and the allocator
// strobe/operand buses seen by alloc_scheduler.
//   slave  : scheduler side (receives requests, drives grants and m_* buses)
//   master : requesters plus allocator side (drives requests and m_alloc_addr)
interface alloc_scheduler_if #(
  parameter int ADDR = 4
);
  // allocate
  logic            a_req;
  logic            a_gnt;
  logic [ADDR-1:0] a_addr;
  // single-entry free
  logic            f_req;
  logic            f_gnt;
  logic [ADDR-1:0] f_addr;
  // vector free
  logic            v_req;
  logic            v_gnt;
  logic [ADDR:0]   v_size;
  logic [ADDR-1:0] v_prev;
  logic [ADDR-1:0] v_start;
  logic [ADDR-1:0] v_snd;
  logic [ADDR-1:0] v_thd;
  logic [ADDR-1:0] v_end;
  logic [ADDR-1:0] v_next;
  logic [ADDR-1:0] v_last;
  // rewind
  logic            rw_req;
  logic            rw_gnt;
  logic [ADDR-1:0] rw_addr;
  logic [ADDR:0]   rw_count;
  // allocator strobes and operands
  logic            m_alloc;
  logic            m_de_alloc;
  logic            m_reset;
  logic            m_de_alloc_vector;
  logic            m_size_is_one;
  logic            m_size_is_two;
  logic [ADDR-1:0] m_last_alloc_addr;
  logic [ADDR-1:0] m_reset_addr;
  logic [ADDR-1:0] m_vector_previous;
  logic [ADDR-1:0] m_vector_start;
  logic [ADDR-1:0] m_vector_snd;
  logic [ADDR-1:0] m_vector_thd;
  logic [ADDR-1:0] m_vector_end;
  logic [ADDR-1:0] m_vector_next;
  logic [ADDR-1:0] m_alloc_addr;
  // status
  logic [ADDR:0]   free_count;
  logic            empty;
  logic            err;

  modport slave (
    input  a_req, f_req, f_addr, v_req, v_size, v_prev, v_start, v_snd, v_thd,
           v_end, v_next, v_last, rw_req, rw_addr, rw_count, m_alloc_addr,
    output a_gnt, a_addr, f_gnt, v_gnt, rw_gnt,
           m_alloc, m_de_alloc, m_reset, m_de_alloc_vector, m_size_is_one,
           m_size_is_two, m_last_alloc_addr, m_reset_addr, m_vector_previous,
           m_vector_start, m_vector_snd, m_vector_thd, m_vector_end,
           m_vector_next, free_count, empty, err
  );

  modport master (
    output a_req, f_req, f_addr, v_req, v_size, v_prev, v_start, v_snd, v_thd,
           v_end, v_next, v_last, rw_req, rw_addr, rw_count, m_alloc_addr,
    input  a_gnt, a_addr, f_gnt, v_gnt, rw_gnt,
           m_alloc, m_de_alloc, m_reset, m_de_alloc_vector, m_size_is_one,
           m_size_is_two, m_last_alloc_addr, m_reset_addr, m_vector_previous,
           m_vector_start, m_vector_snd, m_vector_thd, m_vector_end,
           m_vector_next, free_count, empty, err
  );
endinterface

// File: rtl/alloc_scheduler.sv
// alloc_scheduler: sole driver of one memory_allocator. Arbitrates the
// allocate / free / vector-free / rewind requesters, enforces the allocator's
// port-sharing and link-write pipeline rules, and tracks the free-entry count.
// Optional build macro: ALLOC_SCHED_CHECK_EN enables the sticky protocol
// error flag; without it err is tied low and no checking logic is built.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// UNINIT   | free list not yet set up; only a rewind can be granted
// READY    | all requests eligible
// VTAIL    | allocator writing the vector link on port B; vector free blocked
module alloc_scheduler #(
  parameter int ADDR  = 4,
  parameter int DEPTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  alloc_scheduler_if.slave sched_if
);

  localparam logic [1:0] S_UNINIT = 2'd0;
  localparam logic [1:0] S_READY  = 2'd1;
  localparam logic [1:0] S_VTAIL  = 2'd2;

  // Wide enough to hold free_count + max v_size + 1 without wrapping.
  localparam int CW = ADDR + 3;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR:0] DEPTH_F = DEPTH_C[ADDR:0];

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            w_live;

  logic            w_rw_gnt;
  logic            w_v_gnt;
  logic            w_f_gnt;
  logic            w_a_gnt;

  logic [ADDR:0]   r_free_count;
  logic [ADDR:0]   w_free_count_nxt;
  logic [CW-1:0]   w_up;
  logic [CW-1:0]   w_dn;
  logic [CW-1:0]   w_diff;
  logic            w_unf;
  logic            w_ovf;
  logic            w_rw_ovf;

  logic [ADDR-1:0] r_last_alloc_addr, w_last_alloc_addr;
  logic [ADDR-1:0] r_reset_addr,      w_reset_addr;
  logic [ADDR-1:0] r_vector_previous, w_vector_previous;
  logic [ADDR-1:0] r_vector_start,    w_vector_start;
  logic [ADDR-1:0] r_vector_snd,      w_vector_snd;
  logic [ADDR-1:0] r_vector_thd,      w_vector_thd;
  logic [ADDR-1:0] r_vector_end,      w_vector_end;
  logic [ADDR-1:0] r_vector_next,     w_vector_next;

  assign w_live = (r_state == S_READY) || (r_state == S_VTAIL);

  // Grant arbitration: rw > v > f > a; a may ride along with v only.
  always_comb begin
    w_rw_gnt = sched_if.rw_req;
    w_v_gnt  = !w_rw_gnt && sched_if.v_req && (sched_if.v_size != '0) &&
               (r_state == S_READY);
    w_f_gnt  = !w_rw_gnt && !w_v_gnt && sched_if.f_req && w_live;
    // A co-granted vector free returns entries this same cycle, so the
    // allocator can hand one out even when the list is currently empty.
    w_a_gnt  = !w_rw_gnt && !w_f_gnt && sched_if.a_req && w_live &&
               ((r_free_count != '0) || w_v_gnt);
  end

  // Next-state decode; an illegal encoding falls back to UNINIT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_UNINIT: if (w_rw_gnt) w_state_nxt = S_READY;
      S_READY:  if (!w_rw_gnt && w_v_gnt) w_state_nxt = S_VTAIL;
      S_VTAIL:  w_state_nxt = S_READY;
      default:  w_state_nxt = w_rw_gnt ? S_READY : S_UNINIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_UNINIT;
    else        r_state <= w_state_nxt;
  end

  assign w_up     = CW'(r_free_count) + (w_v_gnt ? CW'(sched_if.v_size) : '0) +
                    CW'(w_f_gnt);
  assign w_dn     = CW'(w_a_gnt);
  assign w_diff   = w_up - w_dn;
  assign w_unf    = (w_up < w_dn);
  assign w_ovf    = (w_diff > DEPTH_C);
  assign w_rw_ovf = (sched_if.rw_count > DEPTH_F);

  // Free-count update with saturation to 0..DEPTH; a rewind overrides.
  always_comb begin
    w_free_count_nxt = r_free_count;
    if (w_rw_gnt)   w_free_count_nxt = w_rw_ovf ? DEPTH_F : sched_if.rw_count;
    else if (w_unf) w_free_count_nxt = '0;
    else if (w_ovf) w_free_count_nxt = DEPTH_F;
    else            w_free_count_nxt = w_diff[ADDR:0];
  end

  // Free-count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_free_count <= '0;
    else        r_free_count <= w_free_count_nxt;
  end

  // Operand buses follow the granted request and otherwise hold.
  always_comb begin
    w_last_alloc_addr = r_last_alloc_addr;
    w_reset_addr      = r_reset_addr;
    w_vector_previous = r_vector_previous;
    w_vector_start    = r_vector_start;
    w_vector_snd      = r_vector_snd;
    w_vector_thd      = r_vector_thd;
    w_vector_end      = r_vector_end;
    w_vector_next     = r_vector_next;
    if (w_v_gnt) begin
      w_last_alloc_addr = sched_if.v_last;
      w_vector_previous = sched_if.v_prev;
      w_vector_start    = sched_if.v_start;
      w_vector_snd      = sched_if.v_snd;
      w_vector_thd      = sched_if.v_thd;
      w_vector_end      = sched_if.v_end;
      w_vector_next     = sched_if.v_next;
    end else if (w_a_gnt) begin
      // Point port A at the entry being handed out so it fetches the next link.
      w_vector_previous = sched_if.m_alloc_addr;
    end
    if (w_f_gnt)  w_last_alloc_addr = sched_if.f_addr;
    if (w_rw_gnt) w_reset_addr      = sched_if.rw_addr;
  end

  // Bus hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_alloc_addr <= '0;
      r_reset_addr      <= '0;
      r_vector_previous <= '0;
      r_vector_start    <= '0;
      r_vector_snd      <= '0;
      r_vector_thd      <= '0;
      r_vector_end      <= '0;
      r_vector_next     <= '0;
    end else begin
      r_last_alloc_addr <= w_last_alloc_addr;
      r_reset_addr      <= w_reset_addr;
      r_vector_previous <= w_vector_previous;
      r_vector_start    <= w_vector_start;
      r_vector_snd      <= w_vector_snd;
      r_vector_thd      <= w_vector_thd;
      r_vector_end      <= w_vector_end;
      r_vector_next     <= w_vector_next;
    end
  end

  assign sched_if.a_gnt             = w_a_gnt;
  assign sched_if.f_gnt             = w_f_gnt;
  assign sched_if.v_gnt             = w_v_gnt;
  assign sched_if.rw_gnt            = w_rw_gnt;
  assign sched_if.a_addr            = sched_if.m_alloc_addr;
  assign sched_if.m_alloc           = w_a_gnt;
  assign sched_if.m_de_alloc        = w_f_gnt;
  assign sched_if.m_reset           = w_rw_gnt;
  assign sched_if.m_de_alloc_vector = w_v_gnt;
  assign sched_if.m_size_is_one     = w_v_gnt && (sched_if.v_size == (ADDR+1)'(1));
  assign sched_if.m_size_is_two     = w_v_gnt && (sched_if.v_size == (ADDR+1)'(2));
  assign sched_if.m_last_alloc_addr = w_last_alloc_addr;
  assign sched_if.m_reset_addr      = w_reset_addr;
  assign sched_if.m_vector_previous = w_vector_previous;
  assign sched_if.m_vector_start    = w_vector_start;
  assign sched_if.m_vector_snd      = w_vector_snd;
  assign sched_if.m_vector_thd      = w_vector_thd;
  assign sched_if.m_vector_end      = w_vector_end;
  assign sched_if.m_vector_next     = w_vector_next;
  assign sched_if.free_count        = r_free_count;
  assign sched_if.empty             = (r_free_count == '0);

`ifdef ALLOC_SCHED_CHECK_EN
  logic r_err;
  logic w_sat;
  logic w_err_evt;

  assign w_sat     = w_rw_gnt ? w_rw_ovf : (w_unf || w_ovf);
  assign w_err_evt = w_sat ||
                     (sched_if.v_req && (sched_if.v_size == '0)) ||
                     (sched_if.v_req && (sched_if.v_size > DEPTH_F)) ||
                     (sched_if.rw_req && w_rw_ovf);

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= r_err || w_err_evt;
  end

  assign sched_if.err = r_err;
`else
  assign sched_if.err = 1'b0;
`endif

endmodule

// File: tb/tb_alloc_scheduler.sv
// tb_alloc_scheduler: directed test-plan steps followed by a randomized phase,
// all checked against a behavioural model of the arbitration rules and the
// free-entry count.
module tb_alloc_scheduler;
  localparam int ADDR  = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alloc_scheduler_if #(.ADDR(ADDR)) sif ();

  alloc_scheduler #(.ADDR(ADDR), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sched_if (sif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int   mfc;
  bit   minit;
  bit   mvtail;
  bit   merr;
  bit   e_a, e_f, e_v, e_rw;
  logic [3:0] e_last, e_reset, e_prev, e_start, e_snd, e_thd, e_end, e_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mfc = 0; minit = 0; mvtail = 0; merr = 0;
    e_last = 0; e_reset = 0; e_prev = 0; e_start = 0;
    e_snd = 0; e_thd = 0; e_end = 0; e_next = 0;
  endtask

  task automatic clear_inputs();
    sif.a_req = 0; sif.f_req = 0; sif.v_req = 0; sif.rw_req = 0;
    sif.f_addr = 0; sif.v_size = 0; sif.v_prev = 0; sif.v_start = 0;
    sif.v_snd = 0; sif.v_thd = 0; sif.v_end = 0; sif.v_next = 0;
    sif.v_last = 0; sif.rw_addr = 0; sif.rw_count = 0; sif.m_alloc_addr = 0;
  endtask

  task automatic rand_inputs();
    sif.a_req        = ($urandom_range(0, 1) == 1);
    sif.f_req        = ($urandom_range(0, 4) < 2);
    sif.v_req        = ($urandom_range(0, 4) < 2);
    sif.rw_req       = ($urandom_range(0, 9) == 0);
    sif.f_addr       = 4'($urandom_range(0, 15));
    sif.v_size       = 5'($urandom_range(0, 17));
    sif.v_prev       = 4'($urandom_range(0, 15));
    sif.v_start      = 4'($urandom_range(0, 15));
    sif.v_snd        = 4'($urandom_range(0, 15));
    sif.v_thd        = 4'($urandom_range(0, 15));
    sif.v_end        = 4'($urandom_range(0, 15));
    sif.v_next       = 4'($urandom_range(0, 15));
    sif.v_last       = 4'($urandom_range(0, 15));
    sif.rw_addr      = 4'($urandom_range(0, 15));
    sif.rw_count     = 5'($urandom_range(0, 17));
    sif.m_alloc_addr = 4'($urandom_range(0, 15));
  endtask

  // Expected grants and bus values from the current requests.
  task automatic predict();
    e_rw = sif.rw_req;
    e_v  = !e_rw && sif.v_req && (sif.v_size != 0) && minit && !mvtail;
    e_f  = !e_rw && !e_v && sif.f_req && minit;
    e_a  = !e_rw && !e_f && sif.a_req && minit && ((mfc > 0) || e_v);
    if (e_v) begin
      e_prev = sif.v_prev;  e_start = sif.v_start; e_snd  = sif.v_snd;
      e_thd  = sif.v_thd;   e_end   = sif.v_end;   e_next = sif.v_next;
      e_last = sif.v_last;
    end else if (e_a) begin
      e_prev = sif.m_alloc_addr;
    end
    if (e_f)  e_last  = sif.f_addr;
    if (e_rw) e_reset = sif.rw_addr;
  endtask

  task automatic check_outputs();
    chk("a_gnt",  sif.a_gnt,  e_a);
    chk("f_gnt",  sif.f_gnt,  e_f);
    chk("v_gnt",  sif.v_gnt,  e_v);
    chk("rw_gnt", sif.rw_gnt, e_rw);
    chk("m_alloc",           sif.m_alloc,           e_a);
    chk("m_de_alloc",        sif.m_de_alloc,        e_f);
    chk("m_de_alloc_vector", sif.m_de_alloc_vector, e_v);
    chk("m_reset",           sif.m_reset,           e_rw);
    chk("m_size_is_one", sif.m_size_is_one, e_v && (sif.v_size == 1));
    chk("m_size_is_two", sif.m_size_is_two, e_v && (sif.v_size == 2));
    chk("a_addr",            sif.a_addr,            sif.m_alloc_addr);
    chk("m_last_alloc_addr", sif.m_last_alloc_addr, e_last);
    chk("m_reset_addr",      sif.m_reset_addr,      e_reset);
    chk("m_vector_previous", sif.m_vector_previous, e_prev);
    chk("m_vector_start",    sif.m_vector_start,    e_start);
    chk("m_vector_snd",      sif.m_vector_snd,      e_snd);
    chk("m_vector_thd",      sif.m_vector_thd,      e_thd);
    chk("m_vector_end",      sif.m_vector_end,      e_end);
    chk("m_vector_next",     sif.m_vector_next,     e_next);
    chk("free_count",        sif.free_count,        mfc);
    chk("empty",             sif.empty,             (mfc == 0));
    chk("err",               sif.err,               merr);
  endtask

  // Advance the model across the coming clock edge.
  task automatic commit();
    int  t;
    bit  sat;
    sat = 0;
    if (e_rw) begin
      t = int'(sif.rw_count);
      if (t > DEPTH) begin t = DEPTH; sat = 1; end
    end else begin
      t = mfc + (e_v ? int'(sif.v_size) : 0) + (e_f ? 1 : 0) - (e_a ? 1 : 0);
      if (t < 0)     begin t = 0;     sat = 1; end
      if (t > DEPTH) begin t = DEPTH; sat = 1; end
    end
`ifdef ALLOC_SCHED_CHECK_EN
    if (sat || (sif.v_req && (sif.v_size == 0)) || (sif.v_req && (sif.v_size > DEPTH)) ||
        (sif.rw_req && (sif.rw_count > DEPTH)))
      merr = 1;
`endif
    mfc    = t;
    if (e_rw) minit = 1;
    mvtail = e_v;
  endtask

  // One clock cycle: inputs already applied just after a falling edge.
  task automatic cycle();
    #2;
    predict();
    check_outputs();
    commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    #2;
    model_reset();
    predict();
    check_outputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int ngr;
    clear_inputs();
    model_reset();

    // reset values
    #2;
    predict();
    check_outputs();
    chk("rst_free_count", sif.free_count, 0);
    chk("rst_empty", sif.empty, 1);
    chk("rst_bus", sif.m_vector_start, 0);
    @(negedge clk);
    rst_n = 1;

    // UNINIT: a and f ignored
    sif.a_req = 1; sif.f_req = 1; sif.f_addr = 4'd6;
    cycle();
    sif.a_req = 1; sif.f_req = 1;
    #1;
    chk("uninit_a", sif.a_gnt, 0);
    chk("uninit_f", sif.f_gnt, 0);
    clear_inputs();

    // rewind to head 3 with 16 entries
    sif.rw_req = 1; sif.rw_addr = 4'd3; sif.rw_count = 5'd16;
    #1;
    chk("rw_gnt", sif.rw_gnt, 1);
    chk("rw_reset_addr", sif.m_reset_addr, 3);
    #0;
    sif.rw_req = 1;
    cycle();
    clear_inputs();
    #1;
    chk("rw_load", sif.free_count, 16);

    // 16 back-to-back allocations, 17th refused
    ngr = 0;
    for (int i = 0; i < 17; i++) begin
      sif.a_req = 1;
      sif.m_alloc_addr = 4'(i);
      #1;
      if (sif.a_gnt === 1'b1) ngr++;
      cycle();
    end
    chk("alloc_burst_count", ngr, 16);
    chk("alloc_empty", sif.empty, 1);
    clear_inputs();

    // vector free plus alloc from an empty list
    sif.v_req = 1; sif.v_size = 5'd3; sif.v_start = 4'd5; sif.v_prev = 4'd2;
    sif.v_snd = 4'd6; sif.v_thd = 4'd7; sif.v_end = 4'd7; sif.v_next = 4'd9;
    sif.v_last = 4'd1; sif.a_req = 1; sif.m_alloc_addr = 4'd5;
    #1;
    chk("va_v_gnt", sif.v_gnt, 1);
    chk("va_a_gnt", sif.a_gnt, 1);
    chk("va_a_addr", sif.a_addr, 5);
    cycle();
    sif.v_req = 0; sif.a_req = 0;
    #1;
    chk("va_free_count", sif.free_count, 2);
    cycle();

    // two vector frees back to back with a single free in between
    sif.v_req = 1; sif.v_size = 5'd2; sif.v_last = 4'd4;
    #1;
    chk("vv_n", sif.v_gnt, 1);
    cycle();
    sif.f_req = 1; sif.f_addr = 4'd9;
    #1;
    chk("vv_n1_v", sif.v_gnt, 0);
    chk("vv_n1_f", sif.f_gnt, 1);
    cycle();
    sif.f_req = 0;
    #1;
    chk("vv_n2", sif.v_gnt, 1);
    cycle();

    // rewind wins in VTAIL and returns to READY
    sif.rw_req = 1; sif.rw_addr = 4'd7; sif.rw_count = 5'd10; sif.a_req = 1;
    #1;
    chk("vt_rw", sif.rw_gnt, 1);
    chk("vt_v", sif.v_gnt, 0);
    chk("vt_a", sif.a_gnt, 0);
    cycle();
    sif.rw_req = 0; sif.a_req = 0; sif.v_size = 5'd1;
    #1;
    chk("vt_ready", sif.v_gnt, 1);
    cycle();
    clear_inputs();
    cycle();

`ifdef ALLOC_SCHED_CHECK_EN
    sif.v_req = 1; sif.v_size = 5'd0;
    #1;
    chk("zero_v_gnt", sif.v_gnt, 0);
    cycle();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      chk("err_sticky", sif.err, 1);
      cycle();
    end
    do_reset();
    chk("err_cleared", sif.err, 0);
`endif

    // randomized phase with occasional mid-operation resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        rand_inputs();
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
